// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, total-period helper, slot address map and sync bundle.
package vga_timing_pkg;

   localparam int unsigned CNT_W        = 11;
   localparam int unsigned DEF_CD       = 12;
   localparam int unsigned DEF_PIX_DIV  = 4;
   localparam int unsigned DEF_SYNC_DLY = 2;

   localparam int unsigned DEF_H_DISP = 640;
   localparam int unsigned DEF_H_FP   = 16;
   localparam int unsigned DEF_H_SYNC = 96;
   localparam int unsigned DEF_H_BP   = 48;
   localparam int unsigned DEF_V_DISP = 480;
   localparam int unsigned DEF_V_FP   = 10;
   localparam int unsigned DEF_V_SYNC = 2;
   localparam int unsigned DEF_V_BP   = 33;

   // Total period of one axis (pixels per line or lines per frame).
   function automatic int unsigned tot(input int unsigned disp, input int unsigned fp,
                                       input int unsigned sync, input int unsigned bp);
      return disp + fp + sync + bp;
   endfunction

   typedef enum logic [1:0] {
      CTRL = 2'd0,
      POS  = 2'd1,
      FCNT = 2'd2
   } slot_addr_e;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic von;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, von: 1'b0};

endpackage

// File: rtl/vga_hv_counter.sv
// Pixel divider plus h/v raster counters; emits registered pix_tick and frame_start.
module vga_hv_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned PIX_DIV = DEF_PIX_DIV,
   parameter int unsigned H_TOT   = 800,
   parameter int unsigned V_TOT   = 525
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] h_o,
   output logic [CNT_W-1:0] v_o,
   output logic             pix_tick_o,
   output logic             frame_start_o
);

   localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             tick_q, tick_d;
   logic             fs_q, fs_d;

   // Ticks and frame_start are registered from next-state so they line up with h/v.
   always_comb begin
      div_d = (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + DIV_W'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (tick_q) begin
         if (h_q == CNT_W'(H_TOT - 1)) begin
            h_d = '0;
            v_d = (v_q == CNT_W'(V_TOT - 1)) ? '0 : v_q + CNT_W'(1);
         end else begin
            h_d = h_q + CNT_W'(1);
         end
      end
      tick_d = (div_d == DIV_W'(PIX_DIV - 1));
      fs_d   = tick_d && (h_d == CNT_W'(H_TOT - 1)) && (v_d == CNT_W'(V_TOT - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= '0;
         h_q    <= '0;
         v_q    <= '0;
         tick_q <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         h_q    <= h_d;
         v_q    <= v_d;
         tick_q <= tick_d;
         fs_q   <= fs_d;
      end
   end

   assign h_o           = h_q;
   assign v_o           = v_q;
   assign pix_tick_o    = tick_q;
   assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_frame_sync_core.sv
// VGA tail stage: raster timing, delayed sync/blank, colour gate and slot registers.
// Optional frame counter at slot address 2 when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_frame_sync_core
   import vga_timing_pkg::*;
#(
   parameter int unsigned CD       = DEF_CD,
   parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
   parameter int unsigned SYNC_DLY = DEF_SYNC_DLY,
   parameter int unsigned H_DISP   = DEF_H_DISP,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_DISP   = DEF_V_DISP,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             write,
   input  logic [13:0]      addr,
   input  logic [31:0]      wr_data,
   output logic [31:0]      rd_data,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             pix_tick,
   output logic             frame_start,
   input  logic [CD-1:0]    si_rgb,
   output logic             hsync,
   output logic             vsync,
   output logic [CD-1:0]    rgb
);

   localparam int unsigned H_TOT     = tot(H_DISP, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOT     = tot(V_DISP, V_FP, V_SYNC, V_BP);
   localparam int unsigned H_SYNC_LO = H_DISP + H_FP;
   localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
   localparam int unsigned V_SYNC_LO = V_DISP + V_FP;
   localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;

   vga_hv_counter #(
      .PIX_DIV (PIX_DIV),
      .H_TOT   (H_TOT),
      .V_TOT   (V_TOT)
   ) u_hv (
      .clk           (clk),
      .reset         (reset),
      .h_o           (x),
      .v_o           (y),
      .pix_tick_o    (pix_tick),
      .frame_start_o (frame_start)
   );

   sync_t      raw_c;
   sync_t      dly_q [SYNC_DLY];
   logic       von_dly;
   logic       wr_c;
   slot_addr_e slot_c;
   logic       ctrl_pend_q, ctrl_pend_d;
   logic       ctrl_q, ctrl_d;
   logic [CD-1:0] rgb_q, rgb_d;
   logic [31:0] fcnt_rd_c;
   logic        unused_bits;

   always_comb begin
      raw_c.hs_n = !((x >= CNT_W'(H_SYNC_LO)) && (x < CNT_W'(H_SYNC_HI)));
      raw_c.vs_n = !((y >= CNT_W'(V_SYNC_LO)) && (y < CNT_W'(V_SYNC_HI)));
      raw_c.von  = (x < CNT_W'(H_DISP)) && (y < CNT_W'(V_DISP));
   end

   // Sync/blank delay line matching the upstream pixel pipeline latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_DLY; i++) dly_q[i] <= SYNC_IDLE;
      end else begin
         dly_q[0] <= raw_c;
         for (int unsigned i = 1; i < SYNC_DLY; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign hsync   = dly_q[SYNC_DLY-1].hs_n;
   assign vsync   = dly_q[SYNC_DLY-1].vs_n;
   assign von_dly = dly_q[SYNC_DLY-1].von;

   assign wr_c        = cs & write;
   assign slot_c      = slot_addr_e'(addr[1:0]);
   assign unused_bits = ^{addr[13:2], wr_data[31:1]};

   // Force-black is staged and only applied at a frame boundary to avoid tearing.
   always_comb begin
      ctrl_pend_d = ctrl_pend_q;
      if (wr_c && (slot_c == CTRL)) ctrl_pend_d = wr_data[0];
      ctrl_d = frame_start ? ctrl_pend_d : ctrl_q;
      rgb_d  = (von_dly && !ctrl_q) ? si_rgb : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_pend_q <= 1'b0;
         ctrl_q      <= 1'b0;
         rgb_q       <= '0;
      end else begin
         ctrl_pend_q <= ctrl_pend_d;
         ctrl_q      <= ctrl_d;
         rgb_q       <= rgb_d;
      end
   end

   assign rgb = rgb_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [31:0] fcnt_q, fcnt_d;

   // Software clear takes priority over a same-cycle frame increment.
   always_comb begin
      fcnt_d = fcnt_q;
      if (wr_c && (slot_c == FCNT)) fcnt_d = '0;
      else if (frame_start)         fcnt_d = fcnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fcnt_q <= '0;
      else       fcnt_q <= fcnt_d;
   end

   assign fcnt_rd_c = fcnt_q;
`else
   assign fcnt_rd_c = '0;
`endif

   always_comb begin
      rd_data = '0;
      case (slot_c)
         CTRL:    rd_data = {31'b0, ctrl_q};
         POS:     rd_data = {5'b0, y, 5'b0, x};
         FCNT:    rd_data = fcnt_rd_c;
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_vga_frame_sync_core.sv
// Randomized scoreboard bench for vga_frame_sync_core using a reduced raster.
module tb_vga_frame_sync_core;

   localparam int unsigned CD = 12, PD = 4, D = 2;
   localparam int unsigned HD = 16, HF = 4, HS = 6, HB = 4;
   localparam int unsigned VD = 8, VF = 2, VS = 2, VB = 3;
   localparam int HT = int'(HD + HF + HS + HB);
   localparam int VT = int'(VD + VF + VS + VB);
   localparam int FRAME = HT * VT * int'(PD);
   localparam int NSTEP = 16000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cs = 1'b0, write = 1'b0;
   logic [13:0]   addr = '0;
   logic [31:0]   wr_data = '0;
   logic [31:0]   rd_data;
   logic [10:0]   x, y;
   logic          pix_tick, frame_start;
   logic [CD-1:0] si_rgb = '0;
   logic          hsync, vsync;
   logic [CD-1:0] rgb;

   always #5 clk = ~clk;

   vga_frame_sync_core #(
      .CD(CD), .PIX_DIV(PD), .SYNC_DLY(D),
      .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .reset(reset), .cs(cs), .write(write), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .x(x), .y(y),
      .pix_tick(pix_tick), .frame_start(frame_start), .si_rgb(si_rgb),
      .hsync(hsync), .vsync(vsync), .rgb(rgb)
   );

   typedef struct {
      logic [10:0]   x, y;
      logic          tick, fs, hs, vs;
      logic [CD-1:0] rgb;
      logic [31:0]   rd;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   active = 1'b0;

   // Raster position as plain arithmetic on clocks elapsed since reset release.
   function automatic int hpos(input int n); return (n / int'(PD)) % HT; endfunction
   function automatic int vpos(input int n); return (n / (int'(PD) * HT)) % VT; endfunction
   function automatic bit is_tick(input int n); return (n % int'(PD)) == int'(PD) - 1; endfunction
   function automatic bit is_fs(input int n);
      return is_tick(n) && hpos(n) == HT - 1 && vpos(n) == VT - 1;
   endfunction
   function automatic bit hs_raw(input int n);
      return !(hpos(n) >= int'(HD + HF) && hpos(n) < int'(HD + HF + HS));
   endfunction
   function automatic bit vs_raw(input int n);
      return !(vpos(n) >= int'(VD + VF) && vpos(n) < int'(VD + VF + VS));
   endfunction
   function automatic bit von_raw(input int n);
      return hpos(n) < int'(HD) && vpos(n) < int'(VD);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Monitor: every clock is an output beat; pop and compare away from the edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (active) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow @%0t: got empty queue want 1 entry", $time);
         end else begin
            e = sb_q.pop_front();
            check("x",           32'(x),           32'(e.x));
            check("y",           32'(y),           32'(e.y));
            check("pix_tick",    32'(pix_tick),    32'(e.tick));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("hsync",       32'(hsync),       32'(e.hs));
            check("vsync",       32'(vsync),       32'(e.vs));
            check("rgb",         32'(rgb),         32'(e.rgb));
            check("rd_data",     rd_data,          e.rd);
         end
      end
   end

   initial begin : driver
      int            n;
      bit            ctrl, pend, rst_now, rst_done, wr, wr0, wr2;
      int            rst_left, r;
      logic [31:0]   fcnt;
      logic [CD-1:0] rgb_exp;
      exp_t          e;
      n = 0; ctrl = 0; pend = 0; fcnt = '0; rgb_exp = '0;
      rst_done = 0; rst_left = 0;

      for (int s = 0; s < NSTEP; s++) begin
         @(posedge clk);
         #1;
         // Mid-frame reset a couple of frames in, inside the blanking region.
         if (!rst_done && n > 2 * FRAME && hpos(n) == int'(HD) + 4 && vpos(n) == int'(VD) + 1) begin
            rst_done = 1;
            rst_left = 3;
         end
         rst_now = (s < 3) || (rst_left > 0);
         if (rst_left > 0) rst_left--;
         reset = rst_now;
         if (rst_now) begin
            n = 0; ctrl = 0; pend = 0; fcnt = '0; rgb_exp = '0;
         end

         si_rgb  = CD'($urandom);
         addr    = 14'($urandom);
         wr_data = $urandom;
         wr      = 1'b0;
         if (!rst_now) begin
            if ($urandom_range(599) == 0) wr = 1'b1;
            if (is_fs(n) && $urandom_range(1) == 1) begin
               wr = 1'b1;
               addr[1:0] = ($urandom_range(1) == 1) ? 2'd0 : 2'd2;
            end
         end
         if (wr) begin
            cs = 1'b1; write = 1'b1;
         end else begin
            r = int'($urandom_range(2));
            cs = (r == 1); write = (r == 2);
         end

         e.x    = 11'(hpos(n));
         e.y    = 11'(vpos(n));
         e.tick = is_tick(n);
         e.fs   = is_fs(n);
         e.hs   = (n >= int'(D)) ? hs_raw(n - int'(D)) : 1'b1;
         e.vs   = (n >= int'(D)) ? vs_raw(n - int'(D)) : 1'b1;
         e.rgb  = rgb_exp;
         case (addr[1:0])
            2'd0: e.rd = {31'b0, ctrl};
            2'd1: e.rd = (vpos(n) << 16) | hpos(n);
`ifdef VGA_SYNC_FRAME_CNT_EN
            2'd2: e.rd = fcnt;
`else
            2'd2: e.rd = 32'd0;
`endif
            default: e.rd = 32'd0;
         endcase
         sb_q.push_back(e);
         active = 1'b1;

         if (!rst_now) begin
            wr0 = wr && addr[1:0] == 2'd0;
            wr2 = wr && addr[1:0] == 2'd2;
            rgb_exp = (n >= int'(D) && von_raw(n - int'(D)) && !ctrl) ? si_rgb : '0;
            if (is_fs(n)) ctrl = wr0 ? wr_data[0] : pend;
            if (wr0) pend = wr_data[0];
            if (wr2) fcnt = '0;
            else if (is_fs(n)) fcnt = fcnt + 32'd1;
            n++;
         end
      end

      @(posedge clk);
      #1;
      active = 1'b0;
      check("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
